frd_stream_dma: RTL and testbench

- Wishbone master that sits directly upstream of the SPI link's bus slave and replaces CPU polling of the ESP32 file-read window.
- Takes one file-read command (file id, offset, byte count), splits it into chunks of at most CHUNK_LEN bytes, and programs the link's FID/OFS/LEN registers.
- Polls the link's CSR for completion, then reads the byte window and emits the data as a little-endian packed 32-bit valid/ready stream (e.g. toward a cache fill or video loader).

---
 rtl/frd_pkg.sv | 24 ++
 rtl/frd_stream_dma_if.sv | 22 ++
 rtl/frd_wb_master.sv | 64 ++++++
 rtl/frd_stream_dma.sv | 177 +++++++++++++++++
 tb/tb_frd_stream_dma.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frd_pkg.sv
// Shared definitions for the file-read stream DMA: link register map,
// CSR status bits and the sequencer state encoding.
package frd_pkg;

  localparam logic [9:0] ADDR_CSR      = 10'h000;
  localparam logic [9:0] ADDR_FID      = 10'h001;
  localparam logic [9:0] ADDR_OFS      = 10'h002;
  localparam logic [9:0] ADDR_LEN      = 10'h003;
  localparam logic [9:0] ADDR_WIN_BASE = 10'h200;

  localparam int CSR_DONE_BIT = 31;
  localparam int CSR_BUSY_BIT = 30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_FID  = 3'd1,
    ST_WR_OFS  = 3'd2,
    ST_WR_LEN  = 3'd3,
    ST_POLL    = 3'd4,
    ST_RD_BYTE = 3'd5,
    ST_PUSH    = 3'd6
  } frd_state_t;

endpackage

// File: rtl/frd_stream_dma_if.sv
// Wishbone-style link bus between the DMA (master) and the SPI link slave.
interface frd_stream_dma_if;

  logic [9:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_wmsk;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );

endinterface

// File: rtl/frd_wb_master.sv
// Single-transaction bus sequencer: holds cyc until ack, then forces at least
// one idle cycle so a still-asserted req cannot restart before the caller moves on.
module frd_wb_master (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             abort,
  input  logic [9:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic             done,
  output logic [31:0]      rdata,
  frd_stream_dma_if.master wb
);

  logic        cyc_r;
  logic        gap_r;
  logic        we_r;
  logic        done_r;
  logic [9:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;

  // Transaction launch, ack capture and inter-cycle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r   <= 1'b0;
      gap_r   <= 1'b0;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      addr_r  <= 10'h000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      done_r <= 1'b0;
      gap_r  <= 1'b0;
      if (abort) begin
        cyc_r <= 1'b0;
        gap_r <= 1'b1;
      end else if (cyc_r) begin
        if (wb.wb_ack) begin
          cyc_r   <= 1'b0;
          done_r  <= 1'b1;
          rdata_r <= wb.wb_rdata;
          gap_r   <= 1'b1;
        end
      end else if (req && !gap_r) begin
        cyc_r   <= 1'b1;
        addr_r  <= addr;
        we_r    <= we;
        wdata_r <= wdata;
      end
    end
  end

  assign wb.wb_cyc   = cyc_r;
  assign wb.wb_we    = we_r;
  assign wb.wb_addr  = addr_r;
  assign wb.wb_wdata = wdata_r;
  assign wb.wb_wmsk  = 4'b0000;
  assign done        = done_r;
  assign rdata       = rdata_r;

endmodule

// File: rtl/frd_stream_dma.sv
// File-read DMA: programs the link per chunk, polls for completion, then
// streams the response window out as packed little-endian 32-bit words.
module frd_stream_dma
  import frd_pkg::*;
#(
  parameter int CHUNK_LEN    = 512,
  parameter int POLL_TIMEOUT = 1048576,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cmd_file_id,
  input  logic [31:0]      cmd_offset,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  frd_stream_dma_if.master wb,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam int IDX_W = $clog2(CHUNK_LEN) + 1;
  localparam int TMO_W = $clog2(POLL_TIMEOUT + 1);

  frd_state_t       state_r, state_next_s;
  logic [31:0]      file_id_r, offset_r, out_data_r;
  logic [CNT_W:0]   remaining_r, chunk_s;
  logic [IDX_W-1:0] chunk_r, idx_r;
  logic [TMO_W-1:0] tmo_r;
  logic [3:0]       out_keep_r;
  logic             out_last_r, out_valid_r, err_r, busy_r, cmd_ready_r;
  logic             req_s, we_s, done_s, poll_ok_s, tmo_hit_s, word_end_s, chunk_end_s;
  logic [9:0]       addr_s;
  logic [31:0]      wdata_s, rdata_s;
  logic             unused_rdata_s;

  assign chunk_s     = (remaining_r > (CNT_W+1)'(CHUNK_LEN)) ? (CNT_W+1)'(CHUNK_LEN) : remaining_r;
  assign poll_ok_s   = done_s && rdata_s[CSR_DONE_BIT] && !rdata_s[CSR_BUSY_BIT];
  assign tmo_hit_s   = (tmo_r == TMO_W'(POLL_TIMEOUT - 1)) && !poll_ok_s;
  assign chunk_end_s = (idx_r == chunk_r - IDX_W'(1));
  assign word_end_s  = (idx_r[1:0] == 2'd3) || chunk_end_s;
  assign unused_rdata_s = ^rdata_s[29:8];

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
      cmd_ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    if (cmd_valid) state_next_s = ST_WR_FID; else state_next_s = ST_IDLE;
      ST_WR_FID:  if (done_s) state_next_s = ST_WR_OFS; else state_next_s = ST_WR_FID;
      ST_WR_OFS:  if (done_s) state_next_s = ST_WR_LEN; else state_next_s = ST_WR_OFS;
      ST_WR_LEN:  if (done_s) state_next_s = ST_POLL; else state_next_s = ST_WR_LEN;
      ST_POLL: begin
        if (poll_ok_s)      state_next_s = ST_RD_BYTE;
        else if (tmo_hit_s) state_next_s = ST_IDLE;
        else                state_next_s = ST_POLL;
      end
      ST_RD_BYTE: if (done_s && word_end_s) state_next_s = ST_PUSH; else state_next_s = ST_RD_BYTE;
      ST_PUSH: begin
        if (!out_ready)                          state_next_s = ST_PUSH;
        else if (idx_r != chunk_r)               state_next_s = ST_RD_BYTE;
        else if (remaining_r != (CNT_W+1)'(0))   state_next_s = ST_WR_LEN;
        else                                     state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bus request decode; PUSH issues nothing so a held word stalls the link.
  always_comb begin
    req_s   = 1'b0;
    we_s    = 1'b0;
    addr_s  = ADDR_CSR;
    wdata_s = 32'h0000_0000;
    case (state_r)
      ST_WR_FID:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_FID; wdata_s = file_id_r; end
      ST_WR_OFS:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_OFS; wdata_s = offset_r; end
      ST_WR_LEN:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_LEN; wdata_s = 32'(chunk_s - (CNT_W+1)'(1)); end
      ST_POLL:    begin req_s = 1'b1; addr_s = ADDR_CSR; end
      ST_RD_BYTE: begin req_s = 1'b1; addr_s = ADDR_WIN_BASE + 10'(idx_r); end
      default:    begin req_s = 1'b0; end
    endcase
  end

  // Command latch, chunk bookkeeping, byte packing and stream hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      file_id_r   <= 32'h0000_0000;
      offset_r    <= 32'h0000_0000;
      remaining_r <= (CNT_W+1)'(0);
      chunk_r     <= IDX_W'(0);
      idx_r       <= IDX_W'(0);
      tmo_r       <= TMO_W'(0);
      out_data_r  <= 32'h0000_0000;
      out_keep_r  <= 4'b0000;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: if (cmd_valid) begin
          file_id_r   <= cmd_file_id;
          offset_r    <= cmd_offset;
          remaining_r <= {1'b0, cmd_len} + (CNT_W+1)'(1);
          err_r       <= 1'b0;
        end
        ST_WR_LEN: if (done_s) begin
          chunk_r     <= chunk_s[IDX_W-1:0];
          remaining_r <= remaining_r - chunk_s;
          idx_r       <= IDX_W'(0);
          tmo_r       <= TMO_W'(0);
          out_data_r  <= 32'h0000_0000;
          out_keep_r  <= 4'b0000;
        end
        ST_POLL: begin
          tmo_r <= tmo_r + TMO_W'(1);
          if (tmo_hit_s) err_r <= 1'b1;
        end
        ST_RD_BYTE: if (done_s) begin
          out_data_r[{idx_r[1:0], 3'b000} +: 8] <= rdata_s[7:0];
          out_keep_r[idx_r[1:0]]                <= 1'b1;
          idx_r                                 <= idx_r + IDX_W'(1);
          if (word_end_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= chunk_end_s && (remaining_r == (CNT_W+1)'(0));
          end
        end
        ST_PUSH: if (out_ready) begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_data_r  <= 32'h0000_0000;
          out_keep_r  <= 4'b0000;
        end
        default: ;
      endcase
    end
  end

  frd_wb_master u_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_s),
    .abort ((state_r == ST_POLL) && tmo_hit_s),
    .addr  (addr_s),
    .we    (we_s),
    .wdata (wdata_s),
    .done  (done_s),
    .rdata (rdata_s),
    .wb    (wb)
  );

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign out_data  = out_data_r;
  assign out_keep  = out_keep_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_frd_stream_dma.sv
// Directed bench for frd_stream_dma: reactive link model plus a word scoreboard.
module tb_frd_stream_dma;
  import frd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_file_id, cmd_offset;
  logic [15:0] cmd_len;
  logic        cmd_valid, cmd_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last, out_valid, out_ready, busy, err;

  frd_stream_dma_if wb ();

  frd_stream_dma #(.CHUNK_LEN(512), .POLL_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_file_id(cmd_file_id), .cmd_offset(cmd_offset), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .wb(wb),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          words_rx = 0;
  int          fid_w, ofs_w, rd_cnt, polls, rd_idx;
  logic [31:0] len_q[$];
  logic [31:0] m_fid, cur_ofs, prev_len;
  logic [9:0]  last_addr;
  bit          first_chunk, never_done, had_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_fn(input logic [31:0] fid, input logic [31:0] p);
    logic [31:0] t;
    t = p * 32'd13 + fid + (p >> 8);
    return t[7:0];
  endfunction

  // Link slave: ack one half-cycle after cyc, auto-advance offset per chunk.
  always @(negedge clk) begin
    if (!rst_n) begin
      wb.wb_ack   = 1'b0;
      wb.wb_rdata = 32'h0;
      had_cyc     = 1'b0;
    end else begin
      if (wb.wb_ack) check("bus_gap", 32'(wb.wb_cyc), 32'd0);
      if (wb.wb_cyc && had_cyc) check("addr_stable", 32'(wb.wb_addr), 32'(last_addr));
      had_cyc   = wb.wb_cyc;
      last_addr = wb.wb_addr;
      if (wb.wb_cyc && !wb.wb_ack) begin
        wb.wb_ack = 1'b1;
        if (wb.wb_we) begin
          case (wb.wb_addr)
            ADDR_FID: begin fid_w++; m_fid = wb.wb_wdata; end
            ADDR_OFS: begin ofs_w++; cur_ofs = wb.wb_wdata; first_chunk = 1'b1; end
            ADDR_LEN: begin
              len_q.push_back(wb.wb_wdata);
              if (!first_chunk) cur_ofs = cur_ofs + prev_len + 32'd1;
              prev_len = wb.wb_wdata;
              first_chunk = 1'b0;
              polls = 0;
              rd_idx = 0;
            end
            default: ;
          endcase
        end else if (wb.wb_addr == ADDR_CSR) begin
          polls++;
          wb.wb_rdata = (!never_done && polls >= 5) ? 32'h8000_0000 : 32'h4000_0000;
        end else begin
          check("win_addr", 32'(wb.wb_addr), 32'(ADDR_WIN_BASE) + 32'(rd_idx));
          wb.wb_rdata = {24'h0, byte_fn(m_fid, cur_ofs + 32'(wb.wb_addr) - 32'h200)};
          rd_idx++;
          rd_cnt++;
        end
      end else begin
        wb.wb_ack = 1'b0;
      end
    end
  end

  // Stream consumer: pop and compare every accepted word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        exp_t        e;
        logic [31:0] m;
        e = exp_q.pop_front();
        m = {{8{e.keep[3]}}, {8{e.keep[2]}}, {8{e.keep[1]}}, {8{e.keep[0]}}};
        check("word_data", out_data & m, e.data & m);
        check("word_keep", 32'(out_keep), 32'(e.keep));
        check("word_last", 32'(out_last), 32'(e.last));
      end
      words_rx++;
    end
  end

  task automatic push_expected(input logic [31:0] fid, input logic [31:0] ofs, input int len_bytes);
    int pos = 0;
    while (pos < len_bytes) begin
      int c;
      c = (len_bytes - pos > 512) ? 512 : len_bytes - pos;
      for (int b = 0; b < c; b += 4) begin
        exp_t e;
        e.data = 32'h0;
        e.keep = 4'b0000;
        for (int k = 0; k < 4 && b + k < c; k++) begin
          e.data[8*k +: 8] = byte_fn(fid, ofs + 32'(pos + b + k));
          e.keep[k] = 1'b1;
        end
        e.last = (pos + b + 4 >= len_bytes);
        exp_q.push_back(e);
      end
      pos += c;
    end
  endtask

  task automatic clear_model();
    fid_w = 0; ofs_w = 0; rd_cnt = 0;
    len_q.delete();
  endtask

  task automatic send_cmd(input logic [31:0] fid, input logic [31:0] ofs, input logic [15:0] len);
    int n = 0;
    @(posedge clk); #1;
    cmd_file_id = fid; cmd_offset = ofs; cmd_len = len; cmd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || out_valid || exp_q.size() != 0) && n < budget);
    check("idle_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int base, n;
    logic [31:0] held;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_file_id = 32'h0; cmd_offset = 32'h0;
    cmd_len = 16'h0; out_ready = 1'b1; never_done = 1'b0; first_chunk = 1'b0;
    m_fid = 32'h0; cur_ofs = 32'h0; prev_len = 32'h0; polls = 0; rd_idx = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cyc", 32'(wb.wb_cyc), 32'd0);
    check("rst_addr", 32'(wb.wb_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // 8-byte transfer.
    clear_model(); base = words_rx;
    push_expected(32'h11, 32'h100, 8);
    send_cmd(32'h11, 32'h100, 16'd7);
    wait_idle(2000);
    check("t1_fid_writes", 32'(fid_w), 32'd1);
    check("t1_ofs_writes", 32'(ofs_w), 32'd1);
    check("t1_len_count", 32'(len_q.size()), 32'd1);
    if (len_q.size() > 0) check("t1_len0", len_q[0], 32'd7);
    check("t1_reads", 32'(rd_cnt), 32'd8);
    check("t1_words", 32'(words_rx - base), 32'd2);
    check("t1_wmsk", 32'(wb.wb_wmsk), 32'd0);

    // 1030-byte transfer across three chunks with a 20-cycle stream stall.
    clear_model(); base = words_rx;
    push_expected(32'h2222, 32'h3000, 1030);
    send_cmd(32'h2222, 32'h3000, 16'd1029);
    n = 0;
    while (words_rx - base < 100 && n < 5000) begin @(negedge clk); n++; end
    check("t2_reach_100", 32'(n < 5000), 32'd1);
    @(posedge clk); #1; out_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    check("t2_stall_valid", 32'(out_valid), 32'd1);
    held = out_data;
    repeat (20) begin
      @(negedge clk);
      check("t2_stall_cyc", 32'(wb.wb_cyc), 32'd0);
      check("t2_stall_data", out_data, held);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_idle(10000);
    check("t2_ofs_writes", 32'(ofs_w), 32'd1);
    check("t2_len_count", 32'(len_q.size()), 32'd3);
    if (len_q.size() == 3) begin
      check("t2_len0", len_q[0], 32'd511);
      check("t2_len1", len_q[1], 32'd511);
      check("t2_len2", len_q[2], 32'd5);
    end
    check("t2_words", 32'(words_rx - base), 32'd258);

    // Poll timeout, then the next accept clears err (1-byte transfer).
    clear_model(); base = words_rx; never_done = 1'b1;
    send_cmd(32'h1, 32'h0, 16'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 1000);
    check("t3_err", 32'(err), 32'd1);
    check("t3_min_cycles", 32'(n >= 64), 32'd1);
    @(negedge clk);
    check("t3_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_no_words", 32'(words_rx - base), 32'd0);
    never_done = 1'b0;
    push_expected(32'hA5, 32'h0, 1);
    send_cmd(32'hA5, 32'h0, 16'd0);
    check("t3_err_cleared", 32'(err), 32'd0);
    wait_idle(2000);
    check("t3_one_word", 32'(words_rx - base), 32'd1);

    // Asynchronous reset during a bus cycle, then a normal transfer.
    clear_model();
    push_expected(32'h33, 32'h40, 16);
    send_cmd(32'h33, 32'h40, 16'd15);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!(wb.wb_cyc && rd_cnt >= 2) && n < 500);
    check("t4_cyc_seen", 32'(wb.wb_cyc), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_cyc_drop", 32'(wb.wb_cyc), 32'd0);
    check("t4_valid_drop", 32'(out_valid), 32'd0);
    check("t4_busy_drop", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    clear_model(); base = words_rx;
    push_expected(32'h44, 32'h8, 4);
    send_cmd(32'h44, 32'h8, 16'd3);
    wait_idle(2000);
    check("t4_words", 32'(words_rx - base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
